// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// slave: the access unit itself; master: the datapath plus memory around it.
interface mem_access_unit_if #(
    parameter int ADDR_W = 7
);
    // datapath request
    logic              i_Req;
    logic              i_We;
    logic [2:0]        i_Funct3;
    logic [31:0]       i_Addr;
    logic [31:0]       i_wData;
    // datapath response
    logic              o_Busy;
    logic              o_Done;
    logic              o_Misaligned;
    logic [31:0]       o_rData;
    // memory port
    logic [ADDR_W-1:0] o_MemAddr;
    logic              o_MemWE;
    logic [31:0]       o_MemWData;
    logic [31:0]       i_MemRData;

    modport slave (
        input  i_Req, i_We, i_Funct3, i_Addr, i_wData, i_MemRData,
        output o_Busy, o_Done, o_Misaligned, o_rData,
        output o_MemAddr, o_MemWE, o_MemWData
    );

    modport master (
        output i_Req, i_We, i_Funct3, i_Addr, i_wData, i_MemRData,
        input  o_Busy, o_Done, o_Misaligned, o_rData,
        input  o_MemAddr, o_MemWE, o_MemWData
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide memory: sub-word RMW stores,
// extended loads, misalign/range errors. Ports: i_Clk, i_Reset (async low), bus.
module mem_access_unit #(
    parameter int MEM_WORDS = 128,
    parameter int ADDR_W    = 7
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    mem_access_unit_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_State;
    logic              r_We;
    logic [2:0]        r_Funct3;
    logic [1:0]        r_Lane;
    logic [31:0]       r_wData;
    logic [ADDR_W-1:0] r_MemAddr;
    logic [31:0]       r_MemWData;
    logic [31:0]       r_rData;
    logic              r_Busy;
    logic              r_Done;
    logic              r_Mis;
    logic              r_MemWE;

    logic              w_BadF3;
    logic              w_HalfMis;
    logic              w_WordMis;
    logic              w_StoreU;
    logic              w_Range;
    logic              w_Err;
    logic [7:0]        w_Byte;
    logic [15:0]       w_Half;
    logic [31:0]       w_LoadVal;
    logic [31:0]       w_StoreVal;
    logic              w_IsB;
    logic              w_IsH;
    logic              w_IsW;

    // request screening on the live inputs, used only when IDLE accepts
    assign w_BadF3   = (bus.i_Funct3 == 3'd3) || (bus.i_Funct3 >= 3'd6);
    assign w_HalfMis = ((bus.i_Funct3 == 3'd1) || (bus.i_Funct3 == 3'd5))
                       && bus.i_Addr[0];
    assign w_WordMis = (bus.i_Funct3 == 3'd2) && (bus.i_Addr[1:0] != 2'b00);
    assign w_StoreU  = bus.i_We
                       && ((bus.i_Funct3 == 3'd4) || (bus.i_Funct3 == 3'd5));
    assign w_Range   = bus.i_Addr[31:2] >= 30'(MEM_WORDS);
    assign w_Err     = w_BadF3 || w_HalfMis || w_WordMis
                       || w_StoreU || w_Range;

    // lane extraction from the word currently addressed
    assign w_Byte = bus.i_MemRData[{r_Lane, 3'b000} +: 8];
    assign w_Half = r_Lane[1] ? bus.i_MemRData[31:16]
                              : bus.i_MemRData[15:0];

    always_comb begin
        w_LoadVal = bus.i_MemRData;
        unique case (r_Funct3)
            3'd0:    w_LoadVal = {{24{w_Byte[7]}}, w_Byte};
            3'd1:    w_LoadVal = {{16{w_Half[15]}}, w_Half};
            3'd4:    w_LoadVal = {24'd0, w_Byte};
            3'd5:    w_LoadVal = {16'd0, w_Half};
            default: w_LoadVal = bus.i_MemRData;
        endcase
    end

    // store size decode; exactly one is always true
    assign w_IsB = (r_Funct3 == 3'd0);
    assign w_IsH = (r_Funct3 == 3'd1);
    assign w_IsW = !(w_IsB || w_IsH);

    always_comb begin
        w_StoreVal = bus.i_MemRData;
        unique case (1'b1)
            w_IsB: w_StoreVal[{r_Lane, 3'b000} +: 8] = r_wData[7:0];
            w_IsH: w_StoreVal[{r_Lane[1], 4'b0000} +: 16] = r_wData[15:0];
            w_IsW: w_StoreVal = r_wData;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State    <= S_IDLE;
            r_We       <= 1'b0;
            r_Funct3   <= 3'd0;
            r_Lane     <= 2'd0;
            r_wData    <= 32'd0;
            r_MemAddr  <= '0;
            r_MemWData <= 32'd0;
            r_rData    <= 32'd0;
            r_Busy     <= 1'b0;
            r_Done     <= 1'b0;
            r_Mis      <= 1'b0;
            r_MemWE    <= 1'b0;
        end else begin
            unique case (r_State)
                S_IDLE: begin
                    if (bus.i_Req) begin
                        r_We      <= bus.i_We;
                        r_Funct3  <= bus.i_Funct3;
                        r_Lane    <= bus.i_Addr[1:0];
                        r_wData   <= bus.i_wData;
                        r_MemAddr <= bus.i_Addr[ADDR_W+1:2];
                        r_Busy    <= 1'b1;
                        if (w_Err) begin
                            r_State <= S_ERR;
                            r_Done  <= 1'b1;
                            r_Mis   <= 1'b1;
                        end else begin
                            r_State <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_We) begin
                        r_MemWData <= w_StoreVal;
                        r_MemWE    <= 1'b1;
                        r_State    <= S_WRITE;
                    end else begin
                        r_rData <= w_LoadVal;
                        r_Done  <= 1'b1;
                        r_State <= S_DONE;
                    end
                end
                S_WRITE: begin
                    r_MemWE <= 1'b0;
                    r_Done  <= 1'b1;
                    r_State <= S_DONE;
                end
                S_DONE, S_ERR: begin
                    r_Done  <= 1'b0;
                    r_Mis   <= 1'b0;
                    r_Busy  <= 1'b0;
                    r_State <= S_IDLE;
                end
                default: begin
                    r_Done  <= 1'b0;
                    r_Mis   <= 1'b0;
                    r_Busy  <= 1'b0;
                    r_MemWE <= 1'b0;
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Busy       = r_Busy;
    assign bus.o_Done       = r_Done;
    assign bus.o_Misaligned = r_Mis;
    assign bus.o_rData      = r_rData;
    assign bus.o_MemAddr    = r_MemAddr;
    assign bus.o_MemWE      = r_MemWE;
    assign bus.o_MemWData   = r_MemWData;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 128-word memory model.
// Checks latency, extension, RMW merges, error pulses and reset abort.
module tb_mem_access_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_access_unit_if #(.ADDR_W(7)) bus ();

    mem_access_unit #(
        .MEM_WORDS(128),
        .ADDR_W   (7)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst_n),
        .bus    (bus)
    );

    logic [31:0] mem [128];
    logic        poke;
    logic [6:0]  poke_a;
    logic [31:0] poke_d;

    assign bus.i_MemRData = mem[bus.o_MemAddr];

    always @(posedge clk) begin
        if (bus.o_MemWE) mem[bus.o_MemAddr] <= bus.o_MemWData;
        else if (poke) mem[poke_a] <= poke_d;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        poke   = 1'b1;
        poke_a = a;
        poke_d = d;
        @(posedge clk);
        #1 poke = 1'b0;
    endtask

    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output int wes, output logic mis,
                       output logic [31:0] wdat, output logic [6:0] maddr);
        @(negedge clk);
        bus.i_Req    = 1'b1;
        bus.i_We     = we;
        bus.i_Funct3 = f3;
        bus.i_Addr   = a;
        bus.i_wData  = wd;
        @(posedge clk);
        lat   = 0;
        wes   = 0;
        mis   = 1'b0;
        wdat  = 32'd0;
        maddr = 7'd0;
        for (int c = 2; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus.i_Req = 1'b0;
                maddr     = bus.o_MemAddr;
            end
            if (bus.o_MemWE) begin
                wes++;
                wdat = bus.o_MemWData;
            end
            if (bus.o_Done) begin
                lat = c;
                mis = bus.o_Misaligned;
                break;
            end
        end
    endtask

    int          lat;
    int          wes;
    logic        mis;
    logic [31:0] wdat;
    logic [6:0]  maddr;
    int          ndone;

    initial begin
        checks       = 0;
        errors       = 0;
        poke         = 1'b0;
        poke_a       = 7'd0;
        poke_d       = 32'd0;
        bus.i_Req    = 1'b0;
        bus.i_We     = 1'b0;
        bus.i_Funct3 = 3'd0;
        bus.i_Addr   = 32'd0;
        bus.i_wData  = 32'd0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.o_Busy), 32'd0);
        chk("rst_done", 32'(bus.o_Done), 32'd0);
        chk("rst_mis", 32'(bus.o_Misaligned), 32'd0);
        chk("rst_we", 32'(bus.o_MemWE), 32'd0);
        chk("rst_rdata", bus.o_rData, 32'd0);
        chk("rst_maddr", 32'(bus.o_MemAddr), 32'd0);
        chk("rst_wdata", bus.o_MemWData, 32'd0);
        rst_n = 1'b1;

        // 1: word load
        put(7'd2, 32'hDEADBEEF);
        run(1'b0, 3'd2, 32'h08, 32'd0, lat, wes, mis, wdat, maddr);
        chk("lw_addr", 32'(maddr), 32'd2);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_data", bus.o_rData, 32'hDEADBEEF);
        chk("lw_we", 32'(wes), 32'd0);
        chk("lw_mis", 32'(mis), 32'd0);

        // 2: sub-word loads
        put(7'd2, 32'h80112233);
        run(1'b0, 3'd0, 32'h0B, 32'd0, lat, wes, mis, wdat, maddr);
        chk("lb_data", bus.o_rData, 32'hFFFFFF80);
        run(1'b0, 3'd4, 32'h0B, 32'd0, lat, wes, mis, wdat, maddr);
        chk("lbu_data", bus.o_rData, 32'h00000080);
        run(1'b0, 3'd1, 32'h0A, 32'd0, lat, wes, mis, wdat, maddr);
        chk("lh_data", bus.o_rData, 32'hFFFF8011);
        chk("lh_lat", 32'(lat), 32'd3);
        run(1'b0, 3'd5, 32'h08, 32'd0, lat, wes, mis, wdat, maddr);
        chk("lhu_data", bus.o_rData, 32'h00002233);

        // 3: byte store read-modify-write
        put(7'd2, 32'h11223344);
        run(1'b1, 3'd0, 32'h09, 32'h000055AA, lat, wes, mis, wdat, maddr);
        chk("sb_lat", 32'(lat), 32'd4);
        chk("sb_we", 32'(wes), 32'd1);
        chk("sb_wdata", wdat, 32'h1122AA44);
        chk("sb_mem", mem[2], 32'h1122AA44);
        run(1'b0, 3'd2, 32'h08, 32'd0, lat, wes, mis, wdat, maddr);
        chk("sb_reread", bus.o_rData, 32'h1122AA44);

        // 4: half and word stores
        put(7'd1, 32'h00000000);
        run(1'b1, 3'd1, 32'h06, 32'h0000BEEF, lat, wes, mis, wdat, maddr);
        chk("sh_mem", mem[1], 32'hBEEF0000);
        chk("sh_we", 32'(wes), 32'd1);
        run(1'b1, 3'd2, 32'h04, 32'h12345678, lat, wes, mis, wdat, maddr);
        chk("sw_mem", mem[1], 32'h12345678);
        chk("sw_lat", 32'(lat), 32'd4);

        // 5: errors
        put(7'd0, 32'h0BADF00D);
        run(1'b0, 3'd2, 32'h06, 32'd0, lat, wes, mis, wdat, maddr);
        chk("e_lw6_lat", 32'(lat), 32'd2);
        chk("e_lw6_mis", 32'(mis), 32'd1);
        chk("e_lw6_rd", bus.o_rData, 32'h1122AA44);
        run(1'b1, 3'd1, 32'h03, 32'h0000FFFF, lat, wes, mis, wdat, maddr);
        chk("e_sh3_lat", 32'(lat), 32'd2);
        chk("e_sh3_mis", 32'(mis), 32'd1);
        chk("e_sh3_we", 32'(wes), 32'd0);
        chk("e_sh3_mem", mem[0], 32'h0BADF00D);
        run(1'b0, 3'd2, 32'h200, 32'd0, lat, wes, mis, wdat, maddr);
        chk("e_rng_lat", 32'(lat), 32'd2);
        chk("e_rng_mis", 32'(mis), 32'd1);
        chk("e_rng_rd", bus.o_rData, 32'h1122AA44);
        run(1'b0, 3'd3, 32'h00, 32'd0, lat, wes, mis, wdat, maddr);
        chk("e_f3_lat", 32'(lat), 32'd2);
        chk("e_f3_mis", 32'(mis), 32'd1);
        run(1'b1, 3'd4, 32'h00, 32'h000000EE, lat, wes, mis, wdat, maddr);
        chk("e_sbu_mis", 32'(mis), 32'd1);
        chk("e_sbu_we", 32'(wes), 32'd0);
        chk("e_sbu_mem", mem[0], 32'h0BADF00D);
        chk("e_sbu_rd", bus.o_rData, 32'h1122AA44);

        // 6a: reset while in WRITE
        put(7'd3, 32'hCAFEF00D);
        @(negedge clk);
        bus.i_Req    = 1'b1;
        bus.i_We     = 1'b1;
        bus.i_Funct3 = 3'd2;
        bus.i_Addr   = 32'h0C;
        bus.i_wData  = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        bus.i_Req = 1'b0;
        @(negedge clk);
        chk("rw_we_pre", 32'(bus.o_MemWE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_we_rst", 32'(bus.o_MemWE), 32'd0);
        chk("rw_busy", 32'(bus.o_Busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rw_mem", mem[3], 32'hCAFEF00D);
        chk("rw_we_post", 32'(bus.o_MemWE), 32'd0);

        // 6b: request held through a busy load
        put(7'd5, 32'h0000007F);
        @(negedge clk);
        bus.i_Req    = 1'b1;
        bus.i_We     = 1'b0;
        bus.i_Funct3 = 3'd0;
        bus.i_Addr   = 32'h14;
        ndone        = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.o_Done) begin
                ndone++;
                bus.i_Req = 1'b0;
            end
        end
        bus.i_Req = 1'b0;
        chk("hold_ndone", 32'(ndone), 32'd1);
        chk("hold_data", bus.o_rData, 32'h0000007F);
        chk("hold_busy", 32'(bus.o_Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
